// File: rtl/rpn_pkg.sv
// rpn_pkg: shared definitions for the RPN stack engine.
//   - opcode encodings carried in tok_data[2:0] of operator tokens
//   - FSM state encoding
//   - depth_w(): width of a counter able to hold 0..DEPTH
package rpn_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_DROP = 3'd6;
    localparam logic [2:0] OP_DIV  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP1,
        S_POP2,
        S_EXEC,
        S_WRB
    } state_e;

    function automatic int depth_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rpn_stack_engine_if.sv
// rpn_stack_engine_if: token stream, result/status and stack-pin bundle.
//   tok_valid/tok_ready/tok_is_op/tok_data : token handshake (upstream -> engine)
//   res_valid/res_data/err/depth           : result strobe and status (engine -> downstream)
//   stk_rReq/stk_wReq/stk_din              : stack requests (engine -> stack)
//   stk_dout/stk_Full/stk_Empty            : stack read data and status (stack -> engine)
// Modports: slave = engine side, master = environment (token source + stack).
interface rpn_stack_engine_if #(
    parameter int WL    = 8,
    parameter int DEPTH = 16
);
    localparam int DW = rpn_pkg::depth_w(DEPTH);

    logic          tok_valid;
    logic          tok_ready;
    logic          tok_is_op;
    logic [WL-1:0] tok_data;
    logic          res_valid;
    logic [WL-1:0] res_data;
    logic          err;
    logic [DW-1:0] depth;
    logic          stk_rReq;
    logic          stk_wReq;
    logic [WL-1:0] stk_din;
    logic [WL-1:0] stk_dout;
    logic          stk_Full;
    logic          stk_Empty;

    modport slave (
        input  tok_valid, tok_is_op, tok_data, stk_dout, stk_Full, stk_Empty,
        output tok_ready, res_valid, res_data, err, depth, stk_rReq, stk_wReq, stk_din
    );

    modport master (
        output tok_valid, tok_is_op, tok_data, stk_dout, stk_Full, stk_Empty,
        input  tok_ready, res_valid, res_data, err, depth, stk_rReq, stk_wReq, stk_din
    );

endinterface

// File: rtl/rpn_alu.sv
// rpn_alu: combinational operator unit.
//   a_i   : second-popped operand (left side, "a" in "a b op")
//   b_i   : first-popped operand (right side)
//   op_i  : opcode
//   res_o : a op b, modulo 2^WL
//   dz_o  : divide by zero (only when built with RPN_DIV_EN)
// Optional macro RPN_DIV_EN enables opcode 7 as unsigned divide.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WL = 8
) (
    input  logic [WL-1:0] a_i,
    input  logic [WL-1:0] b_i,
    input  logic [2:0]    op_i,
    output logic [WL-1:0] res_o,
    output logic          dz_o
);

    always_comb begin
        res_o = '0;
        dz_o  = 1'b0;
        case (op_i)
            OP_ADD: res_o = a_i + b_i;
            OP_SUB: res_o = a_i - b_i;
            OP_MUL: res_o = a_i * b_i;
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_XOR: res_o = a_i ^ b_i;
`ifdef RPN_DIV_EN
            OP_DIV: begin
                // Divide by zero saturates to all-ones and is flagged.
                if (b_i == '0) begin
                    res_o = '1;
                    dz_o  = 1'b1;
                end else begin
                    res_o = a_i / b_i;
                end
            end
`endif
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine: reverse-Polish token evaluator driving an external LIFO.
//   CLK  : clock, rising edge
//   RST  : asynchronous active-low reset
//   bus  : rpn_stack_engine_if.slave (token handshake, result strobe, err,
//          depth, stack push/pop pins)
// Optional macro RPN_DIV_EN: opcode 7 = unsigned divide; otherwise opcode 7
// is rejected at accept.
// The engine keeps its own depth count so illegal pushes/pops are filtered
// before reaching the stack; stk_Full/stk_Empty are only cross-checked.
module rpn_stack_engine
    import rpn_pkg::*;
#(
    parameter int WL    = 8,
    parameter int DEPTH = 16
) (
    input  logic               CLK,
    input  logic               RST,
    rpn_stack_engine_if.slave  bus
);

    localparam int            DW        = depth_w(DEPTH);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0] TWO       = DW'(2);

    state_e        state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [WL-1:0] opnd_q,  opnd_d;
    logic [WL-1:0] b_q,     b_d;
    logic [WL-1:0] res_q,   res_d;
    logic [2:0]    op_q,    op_d;
    logic          rej_q,   rej_d;
    logic          dz_q,    dz_d;

    logic          accept;
    logic          legal;
    logic          chk_err;
    logic [WL-1:0] alu_res;
    logic          alu_dz;

    rpn_alu #(.WL(WL)) u_alu (
        .a_i   (bus.stk_dout),
        .b_i   (b_q),
        .op_i  (op_q),
        .res_o (alu_res),
        .dz_o  (alu_dz)
    );

    assign accept = bus.tok_valid && (state_q == S_IDLE);

    // Token legality from the engine's own occupancy count.
    always_comb begin
        legal = 1'b0;
        if (!bus.tok_is_op) begin
            legal = (depth_q < DEPTH_MAX);
        end else begin
            case (bus.tok_data[2:0])
                OP_DROP: legal = (depth_q != '0);
`ifndef RPN_DIV_EN
                OP_DIV:  legal = 1'b0;
`endif
                default: legal = (depth_q >= TWO);
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        opnd_d  = opnd_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        rej_d   = 1'b0;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!legal) begin
                        rej_d = 1'b1;
                    end else if (!bus.tok_is_op) begin
                        opnd_d  = bus.tok_data;
                        state_d = S_PUSH;
                    end else begin
                        op_d    = bus.tok_data[2:0];
                        state_d = S_POP1;
                    end
                end
            end
            S_PUSH: begin
                depth_d = depth_q + 1'b1;
                state_d = S_IDLE;
            end
            S_POP1: begin
                depth_d = depth_q - 1'b1;
                state_d = (op_q == OP_DROP) ? S_IDLE : S_POP2;
            end
            S_POP2: begin
                // stk_dout now holds the word popped in POP1 (top of stack).
                b_d     = bus.stk_dout;
                depth_d = depth_q - 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d   = alu_res;
                dz_d    = alu_dz;
                state_d = S_WRB;
            end
            S_WRB: begin
                depth_d = depth_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            depth_q <= '0;
            opnd_q  <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= OP_ADD;
            rej_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            opnd_q  <= opnd_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            rej_q   <= rej_d;
            dz_q    <= dz_d;
        end
    end

    // Stack status disagreeing with our own accounting is flagged but the
    // request still goes out.
    assign chk_err = (((state_q == S_POP1) || (state_q == S_POP2)) && bus.stk_Empty) ||
                     (((state_q == S_PUSH) || (state_q == S_WRB))  && bus.stk_Full);

    assign bus.tok_ready = (state_q == S_IDLE);
    assign bus.stk_wReq  = (state_q == S_PUSH) || (state_q == S_WRB);
    assign bus.stk_rReq  = (state_q == S_POP1) || (state_q == S_POP2);
    assign bus.stk_din   = (state_q == S_PUSH) ? opnd_q :
                           (state_q == S_WRB)  ? res_q  : '0;
    assign bus.res_valid = (state_q == S_WRB);
    assign bus.res_data  = res_q;
    assign bus.err       = rej_q || chk_err || ((state_q == S_WRB) && dz_q);
    assign bus.depth     = depth_q;

endmodule

// File: doc/rpn_stack_engine.md
# rpn_stack_engine

Token-driven reverse-Polish evaluator sitting directly upstream of the LIFO stack: it accepts a stream of operand/operator tokens, drives the stack's push/pop request pins, consumes the popped words, computes results and pushes them back. It owns stack-depth accounting so illegal requests never reach the stack. Results are also presented on a one-cycle result strobe for downstream logging/display.

## Interface
Parameters:
- WL, 8, data word width; must match the attached stack.
- DEPTH, 16, stack capacity in words; must match the attached stack.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- tok_valid  in  1  token offered.
- tok_ready  out  1  engine can accept a token this cycle.
- tok_is_op  in  1  1 = operator token, 0 = operand token.
- tok_data  in  WL  operand value, or opcode in bits [2:0] when tok_is_op=1.
- res_valid  out  1  one-cycle strobe: res_data holds a freshly pushed result.
- res_data  out  WL  last result.
- err  out  1  one-cycle strobe: last accepted token was rejected or faulted.
- depth  out  $clog2(DEPTH+1)  current stack occupancy as tracked by the engine.
- stk_rReq  out  1  pop request to stack.
- stk_wReq  out  1  push request to stack.
- stk_din  out  WL  push data.
- stk_dout  in  WL  popped word; registered in the stack, valid the cycle after stk_rReq.
- stk_Full, stk_Empty  in  1  stack status, used only for consistency checking.

## Operation
- Opcodes: 0 ADD, 1 SUB (second-popped minus first-popped, i.e. a-b for tokens "a b -"), 2 MUL (low WL bits), 3 AND, 4 OR, 5 XOR, 6 DROP (pop, discard, no result), 7 reserved (see Configuration).
- All arithmetic modulo 2^WL, unsigned; no carry/overflow flag.
- States: IDLE, PUSH, POP1, POP2, EXEC, WRB.
- IDLE: tok_ready=1. On accept: operand -> PUSH; binary op -> POP1; DROP -> POP1 (then returns to IDLE); illegal token -> stays IDLE, err pulses next cycle.
- Legality checked at accept using depth: operand needs depth<DEPTH; binary op needs depth>=2; DROP needs depth>=1. Rejected tokens are consumed (handshake completes), stack untouched, depth unchanged.
- PUSH: stk_wReq=1, stk_din=operand, depth+1 -> IDLE.
- POP1: stk_rReq=1, depth-1 -> POP2 (binary) or IDLE (DROP).
- POP2: stk_rReq=1, capture b=stk_dout, depth-1 -> EXEC.
- EXEC: a=stk_dout, result=a op b registered -> WRB.
- WRB: stk_wReq=1, stk_din=result, depth+1, res_valid=1, res_data=result -> IDLE.
- stk_rReq and stk_wReq are never asserted together.
- Consistency check: stk_Empty high in POP1/POP2 or stk_Full high in PUSH/WRB raises err; request still issued, FSM continues (debug aid only).

## Timing
- Reset (async assert): state=IDLE, depth=0, res_data=0, res_valid=0, err=0, stk_rReq=0, stk_wReq=0, stk_din=0, tok_ready=1 after release.
- Operand accepted at edge t: stk_wReq high in cycle t+1; tok_ready high again cycle t+2. Throughput 1 operand / 2 cycles.
- Binary op accepted at edge t: POP1 t+1, POP2 t+2, EXEC t+3, WRB t+4 (stk_wReq and res_valid high), tok_ready high t+5.
- err pulses exactly one cycle, the cycle after the offending accept.
- Reset mid-operation aborts immediately; engine depth returns to 0 and the stack must be reset together.

## Configuration
- RPN_DIV_EN defined: opcode 7 = DIV, unsigned a/b; b=0 yields result all-ones, pushed normally, plus err strobe in WRB cycle.
- Undefined: opcode 7 is illegal, rejected at accept with err, stack untouched.

## Structure
- Package rpn_pkg: opcode localparams (OP_ADD..OP_DIV), FSM state encoding, depth width helper.
- One sub-module natural: rpn_alu, purely combinational (a, b, opcode -> result, div_by_zero); FSM, depth counter and handshake remain in rpn_stack_engine.

## Test plan
- Tokens 5, 3, SUB -> stk_wReq pushes 5 then 3, pops 3 then 5, pushes 2; res_valid one cycle with res_data=2; depth 2 then 1.
- 200, 100, ADD with WL=8 -> res_data=44 (wrap), no err.
- ADD with depth=1 -> err pulse, no stk_rReq/stk_wReq, depth stays 1.
- Push 17 operands with DEPTH=16 -> 17th rejected with err, depth=16, stk_wReq count=16.
- Opcode 7: with RPN_DIV_EN, 9, 0, DIV -> res_data=0xFF and err; 9, 2, DIV -> 4; without macro -> err, depth unchanged at 2.
- Assert RST during EXEC -> all outputs to reset values asynchronously, no WRB push, next operand accepted normally.
